// File: rtl/bus_stall_controller_if.sv
// Bus handshake bundle between the IF/MEM bus interfaces and
// the stall controller; master drives requests, slave answers.
interface bus_stall_controller_if #(
    parameter int CNT_W = 8
);
    logic             if_req;
    logic             if_ack;
    logic             mem_req;
    logic             mem_ack;
    logic             if_stb;
    logic             mem_stb;
    logic             stall_pipl;
    logic             bus_timeout;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        output if_req,
        output if_ack,
        output mem_req,
        output mem_ack,
        input  if_stb,
        input  mem_stb,
        input  stall_pipl,
        input  bus_timeout,
        input  wait_cnt
    );

    modport slave (
        input  if_req,
        input  if_ack,
        input  mem_req,
        input  mem_ack,
        output if_stb,
        output mem_stb,
        output stall_pipl,
        output bus_timeout,
        output wait_cnt
    );
endinterface

// File: rtl/bus_stall_controller.sv
// Pipeline stall generator: holds the pipeline until every active
// fetch/data request is acked, with a watchdog that forces release.
module bus_stall_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 8
) (
    input logic                    clk,
    input logic                    reset_n,
    bus_stall_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        TMO  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TO_EN  = (TIMEOUT_CYCLES != 0);

    state_e           state_q, state_d;
    logic             if_done_q, if_done_d;
    logic             mem_done_q, mem_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_tmo;
    logic if_stb, mem_stb;
    logic if_ok, mem_ok;
    logic stall;

    // Strobes and stall are combinational so a same-cycle ack
    // lets the pipeline advance without a bubble.
    always_comb begin
        in_tmo  = (state_q == TMO);
        if_stb  = reset_n & bus.if_req & ~if_done_q & ~in_tmo;
        mem_stb = reset_n & bus.mem_req & ~mem_done_q & ~in_tmo;
        if_ok   = ~bus.if_req | if_done_q | (if_stb & bus.if_ack);
        mem_ok  = ~bus.mem_req | mem_done_q | (mem_stb & bus.mem_ack);
        stall   = reset_n & ~(if_ok & mem_ok) & ~in_tmo;
    end

    assign bus.if_stb      = if_stb;
    assign bus.mem_stb     = mem_stb;
    assign bus.stall_pipl  = stall;
    assign bus.bus_timeout = reset_n & in_tmo;
    assign bus.wait_cnt    = reset_n ? cnt_q : '0;

    // Next-state: per-port done tracking plus watchdog FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        if_done_d  = if_done_q;
        mem_done_d = mem_done_q;

        if (stall) begin
            if (if_stb & bus.if_ack) begin
                if_done_d = 1'b1;
            end
            if (mem_stb & bus.mem_ack) begin
                mem_done_d = 1'b1;
            end
        end else begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
        end

        unique case (state_q)
            RUN: begin
                if (stall) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (!stall) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (TO_EN && (cnt_q == TO_VAL)) begin
                    state_d = TMO;
                end else if (!(&cnt_q)) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            TMO: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State, done flags and wait counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
        end
    end

endmodule

// File: tb/tb_bus_stall_controller.sv
// Directed bench for bus_stall_controller: default watchdog
// instance for handshakes, a short-watchdog instance for timeout.
module tb_bus_stall_controller;

    logic clk;
    logic reset_n;
    int   n_run;
    int   n_fail;

    bus_stall_controller_if #(.CNT_W(8)) b();
    bus_stall_controller_if #(.CNT_W(8)) t();

    bus_stall_controller #(
        .TIMEOUT_CYCLES(255),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(b.slave)
    );

    bus_stall_controller #(
        .TIMEOUT_CYCLES(4),
        .CNT_W(8)
    ) dut_t (
        .clk(clk),
        .reset_n(reset_n),
        .bus(t.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic ir, input logic ia,
                       input logic mr, input logic ma);
        b.if_req  = ir;
        b.if_ack  = ia;
        b.mem_req = mr;
        b.mem_ack = ma;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_run   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        drv(1, 0, 1, 0);
        t.if_req  = 1'b1;
        t.if_ack  = 1'b0;
        t.mem_req = 1'b0;
        t.mem_ack = 1'b0;
        #2;
        check("rst_if_stb", 32'(b.if_stb), 0);
        check("rst_mem_stb", 32'(b.mem_stb), 0);
        check("rst_stall", 32'(b.stall_pipl), 0);
        check("rst_tmo", 32'(b.bus_timeout), 0);
        check("rst_cnt", 32'(b.wait_cnt), 0);
        drv(0, 0, 0, 0);
        t.if_req = 1'b0;
        nxt();
        nxt();
        reset_n = 1'b1;
        nxt();

        // zero-wait
        for (int k = 0; k < 10; k++) begin
            drv(1, 1, 1, 1);
            #4;
            check("zw_stall", 32'(b.stall_pipl), 0);
            check("zw_cnt", 32'(b.wait_cnt), 0);
            check("zw_if_stb", 32'(b.if_stb), 1);
            check("zw_mem_stb", 32'(b.mem_stb), 1);
            nxt();
        end

        // fetch waits 3 cycles, mem acks immediately
        for (int k = 0; k < 4; k++) begin
            drv(1, k == 3, 1, k == 0);
            #4;
            check("fw_stall", 32'(b.stall_pipl), 32'(k < 3));
            check("fw_if_stb", 32'(b.if_stb), 1);
            check("fw_mem_stb", 32'(b.mem_stb), 32'(k == 0));
            check("fw_cnt", 32'(b.wait_cnt), 32'(k));
            nxt();
        end
        drv(0, 0, 0, 0);
        #4;
        check("fw_idle_cnt", 32'(b.wait_cnt), 0);
        check("fw_idle_stall", 32'(b.stall_pipl), 0);
        nxt();

        // skewed acks: mem at 2, fetch at 5
        for (int k = 0; k < 6; k++) begin
            drv(1, k == 5, 1, k == 2);
            #4;
            check("sk_stall", 32'(b.stall_pipl), 32'(k < 5));
            check("sk_if_stb", 32'(b.if_stb), 1);
            check("sk_mem_stb", 32'(b.mem_stb), 32'(k <= 2));
            check("sk_cnt", 32'(b.wait_cnt), 32'(k));
            nxt();
        end
        drv(0, 0, 0, 0);
        nxt();

        // stray mem ack while fetch waits
        for (int k = 0; k < 3; k++) begin
            drv(1, k == 2, 0, 1);
            #4;
            check("st_stall", 32'(b.stall_pipl), 32'(k < 2));
            check("st_mem_stb", 32'(b.mem_stb), 0);
            nxt();
        end
        drv(0, 0, 1, 0);
        #4;
        check("st_mem_stb2", 32'(b.mem_stb), 1);
        check("st_stall2", 32'(b.stall_pipl), 1);
        drv(0, 0, 1, 1);
        #1;
        check("st_stall3", 32'(b.stall_pipl), 0);
        nxt();
        drv(0, 0, 0, 0);
        nxt();

        // reset mid-wait
        for (int k = 0; k < 2; k++) begin
            drv(1, 0, 1, 0);
            #4;
            check("rw_stall", 32'(b.stall_pipl), 1);
            nxt();
        end
        check("rw_cnt_pre", 32'(b.wait_cnt), 2);
        reset_n = 1'b0;
        #1;
        check("rw_stall_rst", 32'(b.stall_pipl), 0);
        check("rw_if_stb_rst", 32'(b.if_stb), 0);
        check("rw_mem_stb_rst", 32'(b.mem_stb), 0);
        check("rw_cnt_rst", 32'(b.wait_cnt), 0);
        check("rw_tmo_rst", 32'(b.bus_timeout), 0);
        nxt();
        reset_n = 1'b1;
        drv(1, 1, 1, 1);
        #4;
        check("rw_new_stall", 32'(b.stall_pipl), 0);
        check("rw_new_if_stb", 32'(b.if_stb), 1);
        check("rw_new_cnt", 32'(b.wait_cnt), 0);
        nxt();
        drv(0, 0, 0, 0);
        #4;
        check("rw_after_cnt", 32'(b.wait_cnt), 0);
        nxt();

        // watchdog on the short-timeout instance
        for (int k = 0; k < 5; k++) begin
            t.if_req  = 1'b1;
            t.mem_req = 1'b1;
            #4;
            check("to_stall", 32'(t.stall_pipl), 1);
            check("to_cnt", 32'(t.wait_cnt), 32'(k));
            check("to_pulse0", 32'(t.bus_timeout), 0);
            nxt();
        end
        t.if_ack = 1'b1;
        #4;
        check("to_pulse", 32'(t.bus_timeout), 1);
        check("to_stall_tmo", 32'(t.stall_pipl), 0);
        check("to_if_stb_tmo", 32'(t.if_stb), 0);
        check("to_mem_stb_tmo", 32'(t.mem_stb), 0);
        nxt();
        t.if_ack = 1'b0;
        #4;
        check("to_pulse_end", 32'(t.bus_timeout), 0);
        check("to_if_stb_re", 32'(t.if_stb), 1);
        check("to_stall_re", 32'(t.stall_pipl), 1);
        check("to_cnt_re", 32'(t.wait_cnt), 0);
        t.if_req  = 1'b0;
        t.mem_req = 1'b0;
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
